// File: rtl/qed_replay_if.sv
// Instruction handshake bundle for qed_replay_buffer: the fetch side in, and the
// decoder side out. The master modport is the buffer's view and the slave modport is the environment's view.
interface qed_replay_if #(
   parameter int IW = 32
);
   logic [IW-1:0] ifu_instruction;
   logic          ifu_valid;
   logic          ifu_ready;
   logic [IW-1:0] ifu_qed_instruction;
   logic          qed_valid;
   logic          qed_ready;
   logic          qed_dup;

   modport master (
      input  ifu_instruction, ifu_valid, qed_ready,
      output ifu_ready, ifu_qed_instruction, qed_valid, qed_dup
   );

   modport slave (
      output ifu_instruction, ifu_valid, qed_ready,
      input  ifu_ready, ifu_qed_instruction, qed_valid, qed_dup
   );
endinterface

// File: rtl/qed_replay_buffer.sv
// SQED instruction source: forwards and captures originals, then replays them as tagged duplicates.
// Optional QED_OPCODE_FILTER_EN: only I/R-type ALU ops are captured; all other ops go out as NOP.
module qed_replay_buffer #(
   parameter int DEPTH = 16,
   parameter int IW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     qed_ena,
   input  logic                     qed_flush,
   qed_replay_if.master             bus,
   output logic                     qed_mode,
   output logic [$clog2(DEPTH):0]   qed_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {
      MODE_ORIG = 1'b0,
      MODE_DUP  = 1'b1
   } mode_e;

`ifdef QED_OPCODE_FILTER_EN
   localparam logic [6:0]    OPC_I     = 7'b0010011;
   localparam logic [6:0]    OPC_R     = 7'b0110011;
   localparam logic [IW-1:0] NOP_INSTR = IW'(32'h0000_0013);
`endif

   mode_e          mode_q, mode_d;
   logic           out_valid_q, out_valid_d;
   logic [IW-1:0]  out_instr_q, out_instr_d;
   logic           out_dup_q, out_dup_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [IW-1:0]  fifo_mem [DEPTH];

   logic           load_en;
   logic           full;
   logic           empty;
   logic           ifu_ready_c;
   logic           accept;
   logic           keep;
   logic [IW-1:0]  fwd_instr;
   logic           push;
   logic           pop;

   // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
   always_comb begin
      load_en     = !out_valid_q || bus.qed_ready;
      full        = (count_q == FULL_CNT);
      empty       = (count_q == '0);
      ifu_ready_c = load_en && (mode_q == MODE_ORIG) && !(qed_ena && full);
      accept      = bus.ifu_valid && ifu_ready_c;
`ifdef QED_OPCODE_FILTER_EN
      keep      = (bus.ifu_instruction[6:0] == OPC_I) || (bus.ifu_instruction[6:0] == OPC_R);
      fwd_instr = (qed_ena && !keep) ? NOP_INSTR : bus.ifu_instruction;
`else
      keep      = 1'b1;
      fwd_instr = bus.ifu_instruction;
`endif
      push = accept && qed_ena && keep;
      pop  = (mode_q == MODE_DUP) && load_en && !empty;
   end

   always_comb begin
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_dup_d   = out_dup_q;
      count_d     = count_q + CW'(push) - CW'(pop);
      wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      if (mode_q == MODE_ORIG) begin
         if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = fwd_instr;
            out_dup_d   = 1'b0;
         end else if (load_en) begin
            out_valid_d = 1'b0;
         end
         // Switch once the FIFO fills, or on flush if anything (including this push) is held.
         if (qed_ena && ((push && count_d == FULL_CNT) || (qed_flush && count_d != '0))) begin
            mode_d = MODE_DUP;
         end
      end else begin
         // qed_ena is deliberately ignored here so every original gets its duplicate.
         if (pop) begin
            out_valid_d = 1'b1;
            out_instr_d = fifo_mem[rd_ptr_q];
            out_dup_d   = 1'b1;
            if (count_d == '0) begin
               mode_d = MODE_ORIG;
            end
         end else if (load_en) begin
            out_valid_d = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= MODE_ORIG;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_dup_q   <= 1'b0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_dup_q   <= out_dup_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // NOTE: storage has no reset; resetting the pointers and count is enough to discard its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= bus.ifu_instruction;
      end
   end

   assign bus.ifu_ready           = ifu_ready_c;
   assign bus.ifu_qed_instruction = out_instr_q;
   assign bus.qed_valid           = out_valid_q;
   assign bus.qed_dup             = out_dup_q;
   assign qed_mode                = mode_q;
   assign qed_count               = count_q;

endmodule

// File: tb/tb_qed_replay_buffer.sv
// Self-checking bench for qed_replay_buffer: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model of the replay behaviour.
module tb_qed_replay_buffer;

   localparam int          DEPTH  = 16;
   localparam int          CW     = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] LW     = 32'h0000_a083;
   localparam logic [31:0] ADD    = 32'h0020_81b3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          qed_ena;
   logic          qed_flush;
   logic          qed_mode;
   logic [CW-1:0] qed_count;

   qed_replay_if #(.IW(32)) bus ();

   qed_replay_buffer #(.DEPTH(DEPTH), .IW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .qed_ena   (qed_ena),
      .qed_flush (qed_flush),
      .bus       (bus),
      .qed_mode  (qed_mode),
      .qed_count (qed_count)
   );

   always #5 clk = ~clk;

   // Reference model state: stored originals, phase, and what the output should show.
   logic [31:0] m_fifo[$];
   bit          m_dup_mode;
   bit          m_valid;
   logic [31:0] m_instr;
   bit          m_dup;

   int n_checks   = 0;
   int n_fail     = 0;
   int dup_taken  = 0;
   int orig_taken = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit keep_instr(input logic [31:0] ins);
`ifdef QED_OPCODE_FILTER_EN
      return (ins[6:0] == 7'b0010011) || (ins[6:0] == 7'b0110011);
`else
      return (ins == ins);
`endif
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      m_dup_mode = 1'b0;
      m_valid    = 1'b0;
      m_instr    = '0;
      m_dup      = 1'b0;
   endtask

   // One clock: drive at negedge, compare just after, advance model at posedge.
   task automatic cycle(input bit v, input logic [31:0] ins, input bit rdy, input bit ena, input bit fl);
      bit exp_ready, load, pushed;
      bus.ifu_valid       = v;
      bus.ifu_instruction = ins;
      bus.qed_ready       = rdy;
      qed_ena             = ena;
      qed_flush           = fl;
      #1;
      load      = !m_valid || rdy;
      exp_ready = load && !m_dup_mode && !(ena && m_fifo.size() == DEPTH);
      check("ifu_ready", 64'(bus.ifu_ready), 64'(exp_ready));
      check("qed_valid", 64'(bus.qed_valid), 64'(m_valid));
      if (m_valid) begin
         check("qed_instruction", 64'(bus.ifu_qed_instruction), 64'(m_instr));
         check("qed_dup", 64'(bus.qed_dup), 64'(m_dup));
      end
      check("qed_mode", 64'(qed_mode), 64'(m_dup_mode));
      check("qed_count", 64'(qed_count), 64'(m_fifo.size()));
      if (bus.qed_valid && rdy) begin
         if (bus.qed_dup) dup_taken++;
         else orig_taken++;
      end
      @(posedge clk);
      pushed = 1'b0;
      if (!m_dup_mode) begin
         if (v && exp_ready) begin
            m_valid = 1'b1;
            m_dup   = 1'b0;
            m_instr = (ena && !keep_instr(ins)) ? NOP : ins;
            if (ena && keep_instr(ins)) begin
               m_fifo.push_back(ins);
               pushed = 1'b1;
            end
         end else if (load) begin
            m_valid = 1'b0;
         end
         if (ena && ((pushed && m_fifo.size() == DEPTH) || (fl && m_fifo.size() > 0)))
            m_dup_mode = 1'b1;
      end else if (load) begin
         if (m_fifo.size() > 0) begin
            m_instr = m_fifo.pop_front();
            m_dup   = 1'b1;
            m_valid = 1'b1;
            if (m_fifo.size() == 0) m_dup_mode = 1'b0;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic clear_taken();
      dup_taken  = 0;
      orig_taken = 0;
   endtask

   initial begin
      bit          ena_r;
      logic [31:0] r;
      logic [6:0]  opc;

      rst_n               = 1'b0;
      qed_ena             = 1'b0;
      qed_flush           = 1'b0;
      bus.ifu_valid       = 1'b0;
      bus.ifu_instruction = '0;
      bus.qed_ready       = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(bus.qed_valid), 64'd0);
      check("rst_instr", 64'(bus.ifu_qed_instruction), 64'd0);
      check("rst_dup", 64'(bus.qed_dup), 64'd0);
      check("rst_mode", 64'(qed_mode), 64'd0);
      check("rst_count", 64'(qed_count), 64'd0);
      rst_n = 1'b1;

      // Fill: 16 ADDI, then fetch stalls and the same 16 come back tagged.
      clear_taken();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h0010_0093 + (32'(i) << 20), 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("fill_orig_count", 64'(orig_taken), 64'(DEPTH));
      check("fill_dup_count", 64'(dup_taken), 64'(DEPTH));

      // Flush together with a push of D, then flush at an empty FIFO.
      clear_taken();
      cycle(1'b1, 32'h0000_0113, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 32'h0000_0213, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 32'h0000_0313, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 32'h0000_0413, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("flush_orig_count", 64'(orig_taken), 64'd4);
      check("flush_dup_count", 64'(dup_taken), 64'd4);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("flush_empty_mode", 64'(qed_mode), 64'd0);

      // Backpressure during replay: ready toggles 1010...
      clear_taken();
      for (int i = 0; i < 6; i++) cycle(1'b1, 32'h0000_5033 + (32'(i) << 20), 1'b1, 1'b1, (i == 5));
      for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, (i % 2 == 0), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("bp_orig_count", 64'(orig_taken), 64'd6);
      check("bp_dup_count", 64'(dup_taken), 64'd6);

      // Pass-through with QED disabled, including a load and stray flushes.
      clear_taken();
      for (int i = 0; i < 20; i++)
         cycle(1'b1, (i == 5) ? LW : 32'h0000_0093 + (32'(i) << 20), 1'b1, 1'b0, (i % 7 == 3));
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("pt_orig_count", 64'(orig_taken), 64'd20);
      check("pt_dup_count", 64'(dup_taken), 64'd0);

`ifdef QED_OPCODE_FILTER_EN
      cycle(1'b1, LW, 1'b1, 1'b1, 1'b0);
      check("filt_lw_out", 64'(bus.ifu_qed_instruction), 64'(NOP));
      check("filt_lw_count", 64'(qed_count), 64'd0);
      cycle(1'b1, ADD, 1'b1, 1'b1, 1'b0);
      check("filt_add_out", 64'(bus.ifu_qed_instruction), 64'(ADD));
      check("filt_add_count", 64'(qed_count), 64'd1);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
`endif

      // Async reset in the middle of a replay with five entries held.
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_0513 + (32'(i) << 20), 1'b1, 1'b1, (i == 4));
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      check("pre_rst_mode", 64'(qed_mode), 64'd1);
      check("pre_rst_count", 64'(qed_count), 64'd5);
      bus.qed_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(bus.qed_valid), 64'd0);
      check("midrst_mode", 64'(qed_mode), 64'd0);
      check("midrst_count", 64'(qed_count), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ifu_ready", 64'(bus.ifu_ready), 64'd1);
      @(negedge clk);

      // Random traffic with occasional enable toggles and flushes.
      ena_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom();
         case ($urandom_range(0, 2))
            0:       opc = 7'b0010011;
            1:       opc = 7'b0110011;
            default: opc = 7'b0000011;
         endcase
         if ($urandom_range(0, 49) == 0) ena_r = ~ena_r;
         cycle($urandom_range(0, 3) != 0, {r[31:7], opc}, $urandom_range(0, 3) != 0,
               ena_r, $urandom_range(0, 24) == 0);
      end
      for (int i = 0; i < DEPTH + 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("final_mode", 64'(qed_mode), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
